// File: rtl/rpn_stack_engine_if.sv
// Command/response and status bundle for the RPN stack engine.
interface rpn_stack_engine_if #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned IN_BITS = 8
);
   localparam int unsigned SW = $clog2(DEPTH + 1);

   logic               cmd_valid;
   logic               cmd_ready;
   logic [3:0]         cmd_op;
   logic [IN_BITS-1:0] cmd_data;
   logic               resp_valid;
   logic [2:0]         err_code;
   logic [WIDTH-1:0]   out_top;
   logic [SW-1:0]      stack_size;
   logic               empty;
   logic               full;

   modport master (
      output cmd_valid, cmd_op, cmd_data,
      input  cmd_ready, resp_valid, err_code, out_top, stack_size, empty, full
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_data,
      output cmd_ready, resp_valid, err_code, out_top, stack_size, empty, full
   );
endinterface

// File: rtl/rpn_stack_engine.sv
// RPN stack engine: register-array operand stack with a serial restoring divider.
module rpn_stack_engine #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned IN_BITS = 8
) (
   input logic               clk,
   input logic               reset,
   rpn_stack_engine_if.slave bus
);
   localparam int unsigned SW = $clog2(DEPTH + 1);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, EXEC, DIV, DONE} state_t;

   typedef enum logic [3:0] {
      OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
      OP_REM = 4'd4, OP_POP = 4'd5, OP_DUP = 4'd6, OP_SWAP = 4'd7,
      OP_PUSH = 4'd8, OP_SHPUSH = 4'd9, OP_NEG = 4'd10, OP_CLEAR = 4'd11
   } op_t;

   typedef enum logic [2:0] {
      ERR_NONE = 3'd0, ERR_UNDER = 3'd1, ERR_OVER = 3'd2,
      ERR_DIV0 = 3'd3, ERR_ILLEGAL = 3'd4
   } err_t;

   state_t             state, state_nxt;
   logic [3:0]         op_q;
   logic [IN_BITS-1:0] data_q;
   logic [WIDTH-1:0]   stk [DEPTH];
   logic [SW-1:0]      size;
   err_t               err_q;

   logic [AW-1:0]      top_idx, sec_idx, push_idx;
   logic [WIDTH-1:0]   t_val, s_val;
   logic               full_w;

   err_t               exec_err;
   logic [SW-1:0]      need;
   logic               illegal, grows, is_div;

   logic [WIDTH-1:0]   div_rem, div_quo, div_den;
   logic [CW-1:0]      div_cnt;
   logic [WIDTH:0]     div_shift, div_trial;
   logic [WIDTH-1:0]   div_rem_nxt, div_quo_nxt;
   logic               div_last;

   // Entry indices are only meaningful when the matching size guard holds.
   assign top_idx  = AW'(size - SW'(1));
   assign sec_idx  = AW'(size - SW'(2));
   assign push_idx = AW'(size);
   assign t_val    = stk[top_idx];
   assign s_val    = stk[sec_idx];
   assign full_w   = (size == SW'(DEPTH));

   assign bus.out_top    = (size == '0) ? '0 : t_val;
   assign bus.stack_size = size;
   assign bus.empty      = (size == '0);
   assign bus.full       = full_w;
   assign bus.err_code   = err_q;

   // Operand checks for the latched opcode, in illegal/underflow/overflow/div0 priority.
   always_comb begin
      need     = '0;
      illegal  = 1'b0;
      grows    = 1'b0;
      exec_err = ERR_NONE;
      case (op_q)
         OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_REM, OP_SWAP: need = SW'(2);
         OP_POP, OP_NEG, OP_SHPUSH:                       need = SW'(1);
         OP_DUP:   begin need = SW'(1); grows = 1'b1; end
         OP_PUSH:  grows = 1'b1;
         OP_CLEAR: ;
         default:  illegal = 1'b1;
      endcase
      is_div = (op_q == OP_DIV) || (op_q == OP_REM);
      if (illegal)                    exec_err = ERR_ILLEGAL;
      else if (size < need)           exec_err = ERR_UNDER;
      else if (grows && full_w)       exec_err = ERR_OVER;
      else if (is_div && s_val == '0) exec_err = ERR_DIV0;
   end

   // One restoring-division step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      div_shift   = {div_rem, div_quo[WIDTH-1]};
      div_trial   = div_shift - {1'b0, div_den};
      div_rem_nxt = div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
      div_quo_nxt = {div_quo[WIDTH-2:0], ~div_trial[WIDTH]};
      div_last    = (div_cnt == CW'(WIDTH - 1));
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt      = state;
      bus.cmd_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) state_nxt = EXEC;
         end
         EXEC: state_nxt = (exec_err == ERR_NONE && is_div) ? DIV : DONE;
         DIV:  if (div_last) state_nxt = DONE;
         DONE: begin
            bus.resp_valid = 1'b1;
            state_nxt      = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Command latch, stack update on entry to DONE, and divider iteration.
   always_ff @(posedge clk) begin
      if (reset) begin
         size    <= '0;
         err_q   <= ERR_NONE;
         div_cnt <= '0;
      end else begin
         case (state)
            IDLE: if (bus.cmd_valid) begin
               op_q   <= bus.cmd_op;
               data_q <= bus.cmd_data;
            end
            EXEC: begin
               if (exec_err != ERR_NONE) begin
                  err_q <= exec_err;
               end else if (is_div) begin
                  div_rem <= '0;
                  div_quo <= t_val;
                  div_den <= s_val;
                  div_cnt <= '0;
               end else begin
                  err_q <= ERR_NONE;
                  case (op_q)
                     OP_ADD:    begin stk[sec_idx] <= t_val + s_val; size <= size - SW'(1); end
                     OP_SUB:    begin stk[sec_idx] <= t_val - s_val; size <= size - SW'(1); end
                     OP_MUL:    begin stk[sec_idx] <= t_val * s_val; size <= size - SW'(1); end
                     OP_POP:    size <= size - SW'(1);
                     OP_DUP:    begin stk[push_idx] <= t_val; size <= size + SW'(1); end
                     OP_SWAP:   begin stk[top_idx] <= s_val; stk[sec_idx] <= t_val; end
                     OP_PUSH:   begin stk[push_idx] <= WIDTH'(data_q); size <= size + SW'(1); end
                     OP_SHPUSH: stk[top_idx] <= (t_val << IN_BITS) | WIDTH'(data_q);
                     OP_NEG:    stk[top_idx] <= '0 - t_val;
                     OP_CLEAR:  size <= '0;
                     default:   ;
                  endcase
               end
            end
            DIV: begin
               div_rem <= div_rem_nxt;
               div_quo <= div_quo_nxt;
               div_cnt <= div_cnt + CW'(1);
               if (div_last) begin
                  stk[sec_idx] <= (op_q == OP_DIV) ? div_quo_nxt : div_rem_nxt;
                  size         <= size - SW'(1);
                  err_q        <= ERR_NONE;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
